rgmii_gmii_rx: RTL and testbench
================================

Name: rgmii_gmii_rx

Overview:
- Portable RGMII-to-GMII receive block with no vendor primitives; clock buffering and division happen outside the block.
- Captures the 4-bit DDR RGMII data and control and assembles 8-bit GMII bytes, at 1000M directly and at 10/100M from nibble pairs.
- Produces GMII rxd/rxdv/rxer/crs and decodes RGMII in-band link status.
- Sits between the PHY pins and the MAC receive path.

Parameters:
- MODE, "DELAYED", clock/data relationship.
  - "DELAYED" or "ALIGNED": capture clock is rgmii_rxclk. Any skew for "ALIGNED" is handled by pin constraints.
  - "SYSTEM": capture clock is inverted rgmii_rxclk.

Ports:
- reset: input, 1. Asynchronous, active-high.
- clk_div: input, 1. rgmii_rxclk divided by 2 (external). Reset-synchronizer clock and 10/100M GMII clock.
- speed: input, 1. 1 = 1000M, 0 = 10/100M. Changes only while reset is asserted.
- rgmii_rxclk: input, 1. 125/25/2.5 MHz from the PHY.
- rgmii_rxdat: input, 4. DDR data.
- rgmii_rxctl: input, 1. DDR control.
- rxclk_x2: output, 1. Capture clock (rgmii_rxclk, or its inverse in SYSTEM mode).
- rxclk: output, 1. GMII clock = speed ? capture clock : clk_div.
- rxd: output, 8. GMII data.
- rxdv: output, 1. GMII data valid.
- rxer: output, 1. GMII error.
- crs: output, 1. Carrier sense.
- ibs_up: output, 1. In-band link up.
- ibs_spd: output, 2. In-band speed: 00 = 10M, 01 = 100M, 10 = 1000M.
- ibs_dplx: output, 1. In-band duplex: 1 = full.

Behaviour:
- Internal reset
  - 4-bit shift register on posedge clk_div, asynchronously cleared by reset; it shifts in 1.
  - rst_in = NOT bit[3]. rst_in therefore deasserts on the 4th clk_div rising edge after reset falls.
  - rst_in asynchronously resets every other register in the block.
- Reset values: rxd = 0, rxdv = 0, rxer = 0, crs = 0, ibs_up = 0, ibs_spd = 10, ibs_dplx = 1. All internal stages are 0 except spd_0 = 10 and dplx_0 = 1.
- DDR capture (same-edge-pipelined)
  - Rising edge k samples rxdat into data_in[3:0] and ctl into ctl_r.
  - The following falling edge samples data_in[7:4] and ctl_f.
  - Both halves become visible together at rising edge k+1.
  - rxdv_in = ctl_r; rxer_in = ctl_r XOR ctl_f.
- Stage 0 (negedge capture clock), speed = 1:
  - data_0 <= data_in; valid_0 <= rxdv_in; error_0 <= rxer_in; odd <= 0.
- Stage 0, speed = 0 (nibble assembly):
  - odd = 0: hold <= data_in[3:0]. odd <= 1 if rxdv_in OR valid_0; otherwise odd stays 0, so the block idles until a frame starts.
  - odd = 1: data_0 <= {data_in[3:0], hold}; valid_0 <= rxdv_in; error_0 <= rxer_in; odd <= 0.
  - The first nibble of a frame is the low nibble of the byte.
  - valid_0 staying 1 keeps pairing continuous through end of frame.
- Stage 1 (posedge rxclk):
  - rxd/rxdv/rxer <= data_0/valid_0/error_0.
  - crs <= valid_0 OR (error_0 AND data_0 is one of 0x0E, 0x0F, 0x1F, 0xFF).
- In-band status
  - Negedge capture clock: when rxdv_in = 0 and rxer_in = 0, up_0 <= data_in[0], spd_0 <= data_in[2:1], dplx_0 <= data_in[3]. Otherwise hold.
  - Posedge capture clock: ibs_up <= up_0; ibs_spd <= up_0 ? spd_0 : 10; ibs_dplx <= up_0 ? dplx_0 : 1.
- Reset asserted mid-frame: all stages clear immediately. The next frame after rst_in release starts with odd = 0.
- Latency at 1000M is fixed: about 2 capture-clock cycles from the rising edge to rxd.

Decomposition:
- Package rgmii_pkg:
  - speed codes SPD_10 = 00, SPD_100 = 01, SPD_1000 = 10;
  - carrier-extend codes 0x0E, 0x0F, 0x1F, 0xFF;
  - reset defaults for ibs_spd and ibs_dplx.
- One sub-module, ddr_in_capture: behavioural same-edge-pipelined DDR input register, parameterised width, with async reset. It is instantiated for 4 data bits plus ctl.

Test Plan:
- Reset: hold reset, then release. rst_in stays high through 3 clk_div rises and clears on the 4th. Outputs match reset values; ibs_spd = 10, ibs_dplx = 1.
- 1000M frame: speed = 1, ctl high on both edges, bytes 0x55×7, 0xD5, 0x12, 0x34 sent low nibble on rise. rxd reproduces the same byte sequence with rxdv = 1 and rxer = 0. After ctl falls, rxdv = 0 with constant latency.
- 100M frame: speed = 0, 25 MHz, nibbles 5,5,…,5,D, then 2,1. rxd shows 0x55…0xD5, then 0x12, at one byte per clk_div period, with rxdv = 1.
- Error and carrier: 1000M with ctl rise = 1 and fall = 0 on byte 0xA5 gives rxer = 1 and crs = 1. With ctl rise = 0, fall = 1 and byte 0x0F, rxer = 1, rxdv = 0, crs = 1. With byte 0x20 under the same ctl pattern, crs = 0.
- In-band status: idle ctl = 0 with data nibble 0xD on both edges gives ibs_up = 1, ibs_spd = 10, ibs_dplx = 1. Nibble 0x3 gives up = 1, spd = 01, dplx = 0. Nibble 0x2 gives up = 0, so spd is forced to 10 and dplx to 1.
- Reset mid-frame: assert reset during a 100M frame. rxdv drops to 0 asynchronously. A new frame after release is assembled with correct nibble order.

Source files
------------

// File: rtl/rgmii_pkg.sv
// rtl/rgmii_pkg.sv - shared constants for the RGMII receive path
package rgmii_pkg;

  // In-band speed codes
  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  // Carrier-extend / false-carrier codes seen with rxer asserted
  localparam logic [7:0] CEXT_0E = 8'h0E;
  localparam logic [7:0] CEXT_0F = 8'h0F;
  localparam logic [7:0] CEXT_1F = 8'h1F;
  localparam logic [7:0] CEXT_FF = 8'hFF;

  // In-band status values reported while the link is down
  localparam logic [1:0] IBS_SPD_RST  = SPD_1000;
  localparam logic       IBS_DPLX_RST = 1'b1;

  function automatic logic is_carrier_ext(input logic [7:0] d);
    return (d == CEXT_0E) || (d == CEXT_0F) || (d == CEXT_1F) || (d == CEXT_FF);
  endfunction

endpackage

// File: rtl/ddr_in_capture.sv
// rtl/ddr_in_capture.sv - same-edge-pipelined DDR input register
module ddr_in_capture #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q_rise,
  output logic [W-1:0] q_fall
);

  logic [W-1:0] rise_0;
  logic [W-1:0] fall_0;

  // Rising-edge sample, then re-time both halves onto the next rising edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_0 <= '0;
      q_rise <= '0;
      q_fall <= '0;
    end else begin
      rise_0 <= d;
      q_rise <= rise_0;
      q_fall <= fall_0;
    end
  end

  // Falling-edge sample of the second half of the DDR word
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      fall_0 <= '0;
    end else begin
      fall_0 <= d;
    end
  end

endmodule

// File: rtl/rgmii_gmii_rx.sv
// rtl/rgmii_gmii_rx.sv - RGMII to GMII receive conversion with in-band status
module rgmii_gmii_rx
  import rgmii_pkg::*;
#(
  parameter string MODE = "DELAYED"
) (
  input  logic       reset,
  input  logic       clk_div,
  input  logic       speed,
  input  logic       rgmii_rxclk,
  input  logic [3:0] rgmii_rxdat,
  input  logic       rgmii_rxctl,
  output logic       rxclk_x2,
  output logic       rxclk,
  output logic [7:0] rxd,
  output logic       rxdv,
  output logic       rxer,
  output logic       crs,
  output logic       ibs_up,
  output logic [1:0] ibs_spd,
  output logic       ibs_dplx
);

  logic [3:0] rst_sync;
  logic       rst_in;
  logic [4:0] cap_r;
  logic [4:0] cap_f;
  logic [7:0] data_in;
  logic       rxdv_in;
  logic       rxer_in;
  logic [7:0] data_0;
  logic       valid_0;
  logic       error_0;
  logic       odd;
  logic [3:0] hold;
  logic       up_0;
  logic [1:0] spd_0;
  logic       dplx_0;

  assign rxclk_x2 = (MODE == "SYSTEM") ? ~rgmii_rxclk : rgmii_rxclk;
  assign rxclk    = speed ? rxclk_x2 : clk_div;

  // Reset stretcher: internal reset releases on the 4th clk_div rise
  always_ff @(posedge clk_div or posedge reset) begin
    if (reset) begin
      rst_sync <= 4'b0000;
    end else begin
      rst_sync <= {rst_sync[2:0], 1'b1};
    end
  end

  assign rst_in = ~rst_sync[3];

  ddr_in_capture #(.W(5)) u_capture (
    .clk    (rxclk_x2),
    .reset  (rst_in),
    .d      ({rgmii_rxctl, rgmii_rxdat}),
    .q_rise (cap_r),
    .q_fall (cap_f)
  );

  assign data_in = {cap_f[3:0], cap_r[3:0]};
  assign rxdv_in = cap_r[4];
  assign rxer_in = cap_r[4] ^ cap_f[4];

  // Stage 0: full bytes at 1000M, low-then-high nibble pairing at 10/100M
  always_ff @(negedge rxclk_x2 or posedge rst_in) begin
    if (rst_in) begin
      data_0  <= 8'h00;
      valid_0 <= 1'b0;
      error_0 <= 1'b0;
      odd     <= 1'b0;
      hold    <= 4'h0;
    end else if (speed) begin
      data_0  <= data_in;
      valid_0 <= rxdv_in;
      error_0 <= rxer_in;
      odd     <= 1'b0;
    end else if (!odd) begin
      hold <= data_in[3:0];
      odd  <= rxdv_in | valid_0;
    end else begin
      data_0  <= {data_in[3:0], hold};
      valid_0 <= rxdv_in;
      error_0 <= rxer_in;
      odd     <= 1'b0;
    end
  end

  // Stage 1: GMII outputs and carrier sense in the GMII clock domain
  always_ff @(posedge rxclk or posedge rst_in) begin
    if (rst_in) begin
      rxd  <= 8'h00;
      rxdv <= 1'b0;
      rxer <= 1'b0;
      crs  <= 1'b0;
    end else begin
      rxd  <= data_0;
      rxdv <= valid_0;
      rxer <= error_0;
      crs  <= valid_0 | (error_0 & is_carrier_ext(data_0));
    end
  end

  // In-band status is only meaningful during normal inter-frame idle
  always_ff @(negedge rxclk_x2 or posedge rst_in) begin
    if (rst_in) begin
      up_0   <= 1'b0;
      spd_0  <= IBS_SPD_RST;
      dplx_0 <= IBS_DPLX_RST;
    end else if (!rxdv_in && !rxer_in) begin
      up_0   <= data_in[0];
      spd_0  <= data_in[2:1];
      dplx_0 <= data_in[3];
    end
  end

  // Publish in-band status, forcing defaults while the link is down
  always_ff @(posedge rxclk_x2 or posedge rst_in) begin
    if (rst_in) begin
      ibs_up   <= 1'b0;
      ibs_spd  <= IBS_SPD_RST;
      ibs_dplx <= IBS_DPLX_RST;
    end else begin
      ibs_up   <= up_0;
      ibs_spd  <= up_0 ? spd_0 : IBS_SPD_RST;
      ibs_dplx <= up_0 ? dplx_0 : IBS_DPLX_RST;
    end
  end

endmodule

// File: tb/tb_rgmii_gmii_rx.sv
// tb/tb_rgmii_gmii_rx.sv - self-checking bench for rgmii_gmii_rx
module tb_rgmii_gmii_rx;

  localparam int HP = 4;
  localparam int Q  = 2;

  typedef struct packed {
    int         c;
    logic [7:0] d;
    logic       dv;
    logic       er;
    logic       cs;
  } rec_t;

  logic       reset;
  logic       clk_div;
  logic       speed;
  logic       rgmii_rxclk;
  logic [3:0] rgmii_rxdat;
  logic       rgmii_rxctl;
  logic       rxclk_x2;
  logic       rxclk;
  logic [7:0] rxd;
  logic       rxdv;
  logic       rxer;
  logic       crs;
  logic       ibs_up;
  logic [1:0] ibs_spd;
  logic       ibs_dplx;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  rec_t mon_q[$];
  rec_t got[$];
  logic [7:0] frame[$];

  rgmii_gmii_rx #(.MODE("DELAYED")) dut (
    .reset       (reset),
    .clk_div     (clk_div),
    .speed       (speed),
    .rgmii_rxclk (rgmii_rxclk),
    .rgmii_rxdat (rgmii_rxdat),
    .rgmii_rxctl (rgmii_rxctl),
    .rxclk_x2    (rxclk_x2),
    .rxclk       (rxclk),
    .rxd         (rxd),
    .rxdv        (rxdv),
    .rxer        (rxer),
    .crs         (crs),
    .ibs_up      (ibs_up),
    .ibs_spd     (ibs_spd),
    .ibs_dplx    (ibs_dplx)
  );

  initial begin
    rgmii_rxclk = 1'b0;
    clk_div     = 1'b0;
    forever begin
      #HP rgmii_rxclk = 1'b1;
      clk_div = ~clk_div;
      #HP rgmii_rxclk = 1'b0;
    end
  end

  always @(posedge rgmii_rxclk) cyc <= cyc + 1;

  always @(posedge rxclk) begin
    #1;
    mon_q.push_back('{c: cyc, d: rxd, dv: rxdv, er: rxer, cs: crs});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic byte_1g(input logic [7:0] b, input logic cr, input logic cf, output int rc);
    @(negedge rgmii_rxclk);
    #Q;
    rgmii_rxdat = b[3:0];
    rgmii_rxctl = cr;
    @(posedge rgmii_rxclk);
    #Q;
    rc = cyc;
    rgmii_rxdat = b[7:4];
    rgmii_rxctl = cf;
  endtask

  task automatic nib_100(input logic [3:0] n, input logic c);
    @(negedge rgmii_rxclk);
    #Q;
    rgmii_rxdat = n;
    rgmii_rxctl = c;
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk_div);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk_div);
      #1;
      chk($sformatf("%s_rst_in_rise%0d", tag, i), 32'(dut.rst_in), 32'(i < 4));
    end
  endtask

  task automatic collect_dv();
    got.delete();
    foreach (mon_q[i]) if (mon_q[i].dv) got.push_back(mon_q[i]);
  endtask

  // Sends frame[] as a 10/100M nibble stream and checks reassembled bytes
  task automatic run_100(input string tag);
    logic [3:0] nibs[$];
    logic [7:0] expb[$];
    foreach (frame[i]) begin
      nibs.push_back(frame[i][3:0]);
      nibs.push_back(frame[i][7:4]);
    end
    for (int i = 0; i < nibs.size() / 2; i++)
      expb.push_back(8'(int'(nibs[2*i]) + 16 * int'(nibs[2*i+1])));
    repeat (4) nib_100(4'h0, 1'b0);
    mon_q.delete();
    foreach (nibs[i]) nib_100(nibs[i], 1'b1);
    repeat (10) nib_100(4'h0, 1'b0);
    collect_dv();
    chk({tag, "_count"}, 32'(got.size()), 32'(expb.size()));
    if (got.size() == expb.size()) begin
      foreach (expb[i]) chk($sformatf("%s_byte%0d", tag, i), 32'(got[i].d), 32'(expb[i]));
      chk({tag, "_rate"}, 32'(got[got.size()-1].c - got[0].c), 32'(2 * (expb.size() - 1)));
    end
  endtask

  initial begin
    int         rc;
    int         rc2;
    int         r_first;
    int         r_last;
    int         idx;
    int         nv;
    logic [7:0] b;
    logic       cr;
    logic       cf;
    logic       er;
    logic [3:0] n;
    logic [7:0] cx[4]  = '{8'h0E, 8'h0F, 8'h1F, 8'hFF};
    logic [7:0] eb[3]  = '{8'hA5, 8'h0F, 8'h20};
    logic       ecr[3] = '{1'b1, 1'b0, 1'b0};
    logic       ecf[3] = '{1'b0, 1'b1, 1'b1};
    logic [3:0] ibn[3] = '{4'hD, 4'h3, 4'h2};

    reset       = 1'b0;
    speed       = 1'b1;
    rgmii_rxdat = 4'h0;
    rgmii_rxctl = 1'b0;
    #1 reset = 1'b1;
    repeat (4) @(posedge clk_div);
    #1;
    chk("rst_rxd", 32'(rxd), 32'h00);
    chk("rst_rxdv", 32'(rxdv), 32'd0);
    chk("rst_rxer", 32'(rxer), 32'd0);
    chk("rst_crs", 32'(crs), 32'd0);
    chk("rst_ibs_up", 32'(ibs_up), 32'd0);
    chk("rst_ibs_spd", 32'(ibs_spd), 32'd2);
    chk("rst_ibs_dplx", 32'(ibs_dplx), 32'd1);
    release_reset("g");

    // 1000M frame: preamble, SFD, fixed bytes, random payload
    frame = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h12, 8'h34};
    repeat (6) frame.push_back(8'($urandom));
    repeat (3) byte_1g(8'h00, 1'b0, 1'b0, rc);
    mon_q.delete();
    r_first = 0;
    r_last  = 0;
    foreach (frame[i]) begin
      byte_1g(frame[i], 1'b1, 1'b1, rc);
      if (i == 0) r_first = rc;
      r_last = rc;
    end
    repeat (6) byte_1g(8'h00, 1'b0, 1'b0, rc);
    collect_dv();
    chk("g_count", 32'(got.size()), 32'(frame.size()));
    if (got.size() == frame.size()) begin
      foreach (frame[i]) begin
        chk($sformatf("g_byte%0d", i), 32'(got[i].d), 32'(frame[i]));
        chk($sformatf("g_rxer%0d", i), 32'(got[i].er), 32'd0);
      end
      chk("g_latency_start", 32'(got[0].c - r_first), 32'd2);
      chk("g_latency_end", 32'(got[got.size()-1].c - r_last), 32'd2);
    end

    // Error and carrier-extend handling, directed then random
    for (int k = 0; k < 12; k++) begin
      if (k < 3) begin
        b = eb[k]; cr = ecr[k]; cf = ecf[k];
      end else begin
        b  = (k % 2 == 0) ? cx[$urandom_range(3)] : 8'($urandom);
        cr = 1'($urandom);
        cf = 1'($urandom);
      end
      er = cr ^ cf;
      mon_q.delete();
      byte_1g(b, cr, cf, rc);
      repeat (4) byte_1g(8'h00, 1'b0, 1'b0, rc2);
      idx = -1;
      foreach (mon_q[i]) if (mon_q[i].c == rc + 2) idx = i;
      chk($sformatf("e%0d_found", k), 32'(idx >= 0), 32'd1);
      if (idx >= 0) begin
        chk($sformatf("e%0d_rxd", k), 32'(mon_q[idx].d), 32'(b));
        chk($sformatf("e%0d_rxdv", k), 32'(mon_q[idx].dv), 32'(cr));
        chk($sformatf("e%0d_rxer", k), 32'(mon_q[idx].er), 32'(er));
        chk($sformatf("e%0d_crs", k), 32'(mon_q[idx].cs),
            32'(cr || (er && (b inside {8'h0E, 8'h0F, 8'h1F, 8'hFF}))));
      end
    end

    // In-band link status decoded from idle nibbles
    for (int k = 0; k < 8; k++) begin
      n  = (k < 3) ? ibn[k] : 4'($urandom);
      nv = int'(n);
      repeat (4) byte_1g({n, n}, 1'b0, 1'b0, rc);
      chk($sformatf("ib%0d_up", k), 32'(ibs_up), 32'(nv % 2));
      chk($sformatf("ib%0d_spd", k), 32'(ibs_spd), 32'((nv % 2 == 1) ? (nv / 2) % 4 : 2));
      chk($sformatf("ib%0d_dplx", k), 32'(ibs_dplx), 32'((nv % 2 == 1) ? nv / 8 : 1));
    end

    // 10/100M frame from nibble pairs
    repeat (2) byte_1g(8'h00, 1'b0, 1'b0, rc);
    reset = 1'b1;
    speed = 1'b0;
    repeat (3) @(posedge clk_div);
    release_reset("m");
    frame = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h12};
    repeat (4) frame.push_back(8'($urandom));
    run_100("m");

    // Reset asserted part-way through a 10/100M frame
    repeat (21) nib_100(4'h5, 1'b1);
    chk("mid_rxdv_before", 32'(rxdv), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rxdv_async", 32'(rxdv), 32'd0);
    chk("mid_rxd_async", 32'(rxd), 32'h00);
    rgmii_rxctl = 1'b0;
    rgmii_rxdat = 4'h0;
    repeat (3) @(posedge clk_div);
    release_reset("r");
    frame = '{8'h55, 8'hD5};
    repeat (5) frame.push_back(8'($urandom));
    run_100("r");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
